// File: rtl/uart_reg_responder.sv
// Byte-frame command responder: parses write (A5,addr,data) and read (5A,addr) frames from a UART
// receiver, updates an internal register file and returns read data through the UART transmitter.
module uart_reg_responder #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int TIMEOUT       = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      RX_P_DATA,
    input  logic                  RX_DATA_VALID,
    output logic [WIDTH-1:0]      TX_P_DATA,
    output logic                  TX_DATA_VALID,
    input  logic                  TX_BUSY,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [WIDTH-1:0]      WR_DATA,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN
);

    localparam int                       DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [WIDTH-1:0]         CMD_WRITE = WIDTH'(8'hA5);
    localparam logic [WIDTH-1:0]         CMD_READ  = WIDTH'(8'h5A);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_SEND,
        S_WAIT_ACK
    } state_t;

    state_t                   r_state;
    logic                     r_op_write;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]         r_regs [DEPTH];

    state_t                   w_next_state;
    logic                     w_accept;
    logic                     w_timed;
    logic                     w_cnt_hit;
    logic                     w_timeout;
    logic                     w_bad_cmd;
    logic                     w_write;
    logic                     w_launch;
    logic                     w_overrun;
    logic [TIMEOUT_WIDTH-1:0] w_next_cnt;

    assign w_timed   = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA) || (r_state == S_WAIT_ACK);
    assign w_cnt_hit = (r_cnt == CNT_LAST);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        w_bad_cmd    = 1'b0;
        w_write      = 1'b0;
        w_launch     = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RX_DATA_VALID) begin
                    w_accept = 1'b1;
                    if (RX_P_DATA == CMD_WRITE || RX_P_DATA == CMD_READ) begin
                        w_next_state = S_GET_ADDR;
                    end else begin
                        w_bad_cmd = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (RX_DATA_VALID) begin
                    w_accept     = 1'b1;
                    w_next_state = r_op_write ? S_GET_DATA : S_SEND;
                end else if (w_cnt_hit) begin
                    w_timeout = 1'b1;
                end
            end
            S_GET_DATA: begin
                if (RX_DATA_VALID) begin
                    w_accept     = 1'b1;
                    w_write      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_cnt_hit) begin
                    w_timeout = 1'b1;
                end
            end
            S_SEND: begin
                w_overrun = RX_DATA_VALID;
                if (!TX_BUSY) begin
                    w_launch     = 1'b1;
                    w_next_state = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                w_overrun = RX_DATA_VALID;
                if (TX_BUSY) begin
                    w_next_state = S_IDLE;
                end else if (w_cnt_hit) begin
                    w_timeout = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = S_IDLE;
        end
    end

    // A byte arriving on the limit edge is counted as accepted, so it beats the timeout.
    always_comb begin
        if (w_accept || w_timeout || (w_next_state != r_state) || !w_timed) begin
            w_next_cnt = '0;
        end else begin
            w_next_cnt = r_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == S_IDLE && w_accept) begin
                r_op_write <= (RX_P_DATA == CMD_WRITE);
            end
            if (r_state == S_GET_ADDR && w_accept) begin
                r_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
            end
        end
    end

    // NOTE: the register file is small and must read back zero after reset, so it is flop-based and reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[r_addr] <= RX_P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            WR_EN         <= 1'b0;
            WR_ADDR       <= '0;
            WR_DATA       <= '0;
            FRAME_ERR     <= 1'b0;
            OVERRUN       <= 1'b0;
        end else begin
            TX_DATA_VALID <= w_launch;
            WR_EN         <= w_write;
            FRAME_ERR     <= w_bad_cmd || w_timeout;
            OVERRUN       <= w_overrun;
            if (w_launch) begin
                TX_P_DATA <= r_regs[r_addr];
            end
            if (w_write) begin
                WR_ADDR <= r_addr;
                WR_DATA <= RX_P_DATA;
            end
        end
    end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Command responder on the parallel side of the UART. It parses byte frames delivered by the UART receiver and executes register writes and reads on an internal register file. Read data goes back to the host through the UART transmitter's parallel input, paced by that transmitter's busy flag. This makes the UART link usable as a host-driven register-access port.

## Interface
Parameters:
- WIDTH, 8: data/byte width.
- ADDR_WIDTH, 4: register address width; the register file holds 2**ADDR_WIDTH entries.
- TIMEOUT_WIDTH, 16: width of the timeout counter.
- TIMEOUT, 50000: idle-cycle limit for a partial frame or a missing TX acknowledge.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  WIDTH  received byte, valid only when RX_DATA_VALID=1.
- RX_DATA_VALID  in  1  one-cycle strobe per received byte.
- TX_P_DATA  out  WIDTH  response byte to the transmitter.
- TX_DATA_VALID  out  1  one-cycle strobe that launches a TX frame.
- TX_BUSY  in  1  transmitter busy flag.
- WR_EN  out  1  one-cycle pulse when a register is written.
- WR_ADDR  out  ADDR_WIDTH  address of the write.
- WR_DATA  out  WIDTH  data of the write.
- FRAME_ERR  out  1  one-cycle pulse on a bad command byte or any timeout.
- OVERRUN  out  1  one-cycle pulse when a byte arrives in SEND or WAIT_ACK; that byte is dropped.

## Operation
Frame format:
- Write: 0xA5, addr, data.
- Read: 0x5A, addr. The response is one byte, reg[addr].
- Only addr[ADDR_WIDTH-1:0] is used; the upper address bits are ignored.

States:
- IDLE:
  - Byte 0xA5 -> GET_ADDR with op=write.
  - Byte 0x5A -> GET_ADDR with op=read.
  - Any other byte -> FRAME_ERR pulse; stay in IDLE.
- GET_ADDR: on a byte, latch the address.
  - op=write -> GET_DATA.
  - op=read -> SEND.
- GET_DATA: on a byte, reg[addr] <= byte, WR_EN/WR_ADDR/WR_DATA asserted -> IDLE.
- SEND: when TX_BUSY=0, drive TX_P_DATA <= reg[addr] and TX_DATA_VALID <= 1 for one cycle -> WAIT_ACK.
- WAIT_ACK: when TX_BUSY=1 -> IDLE.

Timeout counter:
- Cleared on every accepted byte and on every state change.
- Increments in GET_ADDR, GET_DATA and WAIT_ACK.
- Reaching TIMEOUT -> IDLE, FRAME_ERR pulse, counter cleared.
- SEND has no timeout; it waits indefinitely for TX_BUSY=0.

Other rules:
- Bytes arriving in SEND or WAIT_ACK are dropped and pulse OVERRUN; the state is unaffected.
- The register file is internal, is written only by frames, and has reset value 0 in every entry.

## Timing
Reset values (RST low, asynchronous):
- State = IDLE, all registers = 0, timeout counter = 0.
- TX_P_DATA=0, TX_DATA_VALID=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, FRAME_ERR=0, OVERRUN=0.

Output registration and latency:
- All outputs are registered.
- Write latency: data byte strobe at edge n -> WR_EN high for cycle n+1. The register updates at that same edge.
- Read latency: addr byte strobe at edge n -> SEND during cycle n+1 -> TX_DATA_VALID high during cycle n+2 if TX_BUSY=0. Otherwise TX_DATA_VALID goes high the cycle after TX_BUSY is first sampled low.
- TX_DATA_VALID is never high for two consecutive cycles. It is never re-asserted before TX_BUSY has been seen high or a timeout has occurred.

Boundary conditions:
- A read issued immediately after a write to the same address returns the new data.
- Byte strobe on the same edge the counter reaches TIMEOUT: the byte wins and the frame continues.
- Bad command byte and timeout cannot coincide (the timeout is inactive in IDLE).
- Reset asserted mid-frame or mid-SEND aborts the frame and loses no register contents other than through reset itself.
- TX_BUSY already high on SEND entry: wait for it to go low before launching.

## Test plan
- Reset, then write frame A5,03,C7 -> WR_EN one cycle with WR_ADDR=3, WR_DATA=0xC7. Then read frame 5A,03 -> TX_DATA_VALID one cycle with TX_P_DATA=0xC7, 2 cycles after the addr strobe.
- Read 5A,0F after reset -> TX_P_DATA=0x00. Read 5A,F2 after writing A5,02,11 -> TX_P_DATA=0x11 (upper address bits ignored).
- Byte 0x33 in IDLE -> FRAME_ERR pulse, no WR_EN. A following A5,01,22 frame completes normally.
- Send A5,04, then no byte for TIMEOUT cycles -> FRAME_ERR pulse and return to IDLE. Then send 5A,04 -> response 0x00 (no write occurred).
- Hold TX_BUSY=1 during a read, release after 40 cycles -> TX_DATA_VALID exactly 1 cycle after release. Inject a byte in WAIT_ACK -> OVERRUN pulse and the byte is ignored.
- Assert RST in the middle of GET_DATA -> all outputs 0 immediately. After release, A5,00,FF writes correctly.
